// File: rtl/display_pkg.sv
// display_pkg: shared types and widths for the display sequencer slice.
package display_pkg;
  localparam int CODE_W = 5;
  localparam int SEG_W = 7;
  typedef enum logic [1:0] {IDLE = 2'd0, SHOW = 2'd1, FIM = 2'd2} state_t;
endpackage

// File: rtl/display_sequencer_if.sv
// display_sequencer_if: upstream write port, playback control and Display-side signals.
interface display_sequencer_if
  import display_pkg::*;
#(
  parameter int DEPTH = 8,
  parameter int CNTW = 4
);
  logic wr_valid;
  logic [CODE_W-1:0] wr_E;
  logic wr_P;
  logic wr_ready;
  logic start;
  logic [CODE_W-1:0] E;
  logic P;
  logic validade;
  logic busy;
  logic done;
  logic [CNTW-1:0] erros;
  logic [$clog2(DEPTH):0] count;
  modport master (
    output wr_valid, wr_E, wr_P, start, validade,
    input wr_ready, E, P, busy, done, erros, count
  );
  modport slave (
    input wr_valid, wr_E, wr_P, start, validade,
    output wr_ready, E, P, busy, done, erros, count
  );
endinterface

// File: rtl/display_char_buffer.sv
// display_char_buffer: DEPTH x {P,E} register array, indexed write, sync clear, comb read.
module display_char_buffer
  import display_pkg::*;
#(
  parameter int DEPTH = 8,
  localparam int AW = $clog2(DEPTH)
) (
  input  logic clk,
  input  logic rst,
  input  logic we,
  input  logic clr,
  input  logic [AW-1:0] wr_idx,
  input  logic [AW-1:0] rd_idx,
  input  logic [CODE_W:0] wr_data,
  output logic [CODE_W:0] rd_data
);
  logic [CODE_W:0] mem [DEPTH];
  always_ff @(posedge clk or posedge rst) begin
    if (rst || clr) begin
      for (int i = 0; i < DEPTH; i++) mem[i] <= '0;
    end else if (we) begin
      mem[wr_idx] <= wr_data;
    end
  end
  assign rd_data = mem[rd_idx];
endmodule

// File: rtl/display_sequencer.sv
// display_sequencer: buffers {P,E} characters and plays them to Display, one per dwell period,
// counting characters Display reports as invalid.
module display_sequencer
  import display_pkg::*;
#(
  parameter int DEPTH = 8,
  parameter int DWELL = 4,
  parameter int CNTW = 4
) (
  input logic clk,
  input logic rst,
  display_sequencer_if.slave bus
);
  localparam int AW = $clog2(DEPTH);
  localparam int DW = $clog2(DWELL);
  state_t state, state_n;
  logic [AW-1:0] wr_ptr, wr_ptr_n, rd_ptr, rd_ptr_n, rd_idx;
  logic [AW:0] cnt, cnt_n;
  logic [DW-1:0] dwell, dwell_n;
  logic [CNTW-1:0] erros, erros_n;
  logic [CODE_W:0] ep, ep_n, rd_data;
  logic busy, busy_n, done, done_n, rdy, rdy_n, we, clr;
  display_char_buffer #(.DEPTH(DEPTH)) u_buf (
    .clk(clk), .rst(rst), .we(we), .clr(clr), .wr_idx(wr_ptr), .rd_idx(rd_idx),
    .wr_data({bus.wr_P, bus.wr_E}), .rd_data(rd_data)
  );
  // In IDLE the read port looks at entry 0 so start can load it; in SHOW it looks one ahead.
  assign rd_idx = (state == IDLE) ? '0 : rd_ptr + 1'b1;
  always_comb begin
    state_n = state;
    wr_ptr_n = wr_ptr;
    rd_ptr_n = rd_ptr;
    cnt_n = cnt;
    dwell_n = dwell;
    erros_n = erros;
    ep_n = ep;
    busy_n = busy;
    done_n = 1'b0;
    we = 1'b0;
    clr = 1'b0;
    case (state)
      IDLE: begin
        we = bus.wr_valid && rdy;
        wr_ptr_n = wr_ptr + AW'(we);
        cnt_n = cnt + (AW+1)'(we);
        if (bus.start) begin
          erros_n = '0;
          rd_ptr_n = '0;
          dwell_n = '0;
          state_n = (cnt_n != '0) ? SHOW : FIM;
          busy_n = (cnt_n != '0);
          done_n = (cnt_n == '0);
          // A same-cycle write into an empty buffer is entry 0 and bypasses the array.
          ep_n = (cnt == '0) ? {bus.wr_P, bus.wr_E} : rd_data;
          ep_n = (cnt_n != '0) ? ep_n : '0;
        end
      end
      SHOW: begin
        dwell_n = dwell + 1'b1;
        if (dwell == DW'(DWELL - 1)) begin
          erros_n = (!bus.validade && erros != '1) ? erros + 1'b1 : erros;
          dwell_n = '0;
          if ((AW+1)'(rd_ptr) == cnt - 1'b1) begin
            state_n = FIM;
            done_n = 1'b1;
            busy_n = 1'b0;
            ep_n = '0;
            cnt_n = '0;
            wr_ptr_n = '0;
            clr = 1'b1;
          end else begin
            rd_ptr_n = rd_ptr + 1'b1;
            ep_n = rd_data;
          end
        end
      end
      default: state_n = IDLE;
    endcase
    rdy_n = (state_n == IDLE) && (cnt_n != (AW+1)'(DEPTH));
  end
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= IDLE;
      wr_ptr <= '0;
      rd_ptr <= '0;
      cnt <= '0;
      dwell <= '0;
      erros <= '0;
      ep <= '0;
      busy <= 1'b0;
      done <= 1'b0;
      rdy <= 1'b1;
    end else begin
      state <= state_n;
      wr_ptr <= wr_ptr_n;
      rd_ptr <= rd_ptr_n;
      cnt <= cnt_n;
      dwell <= dwell_n;
      erros <= erros_n;
      ep <= ep_n;
      busy <= busy_n;
      done <= done_n;
      rdy <= rdy_n;
    end
  end
  assign bus.E = ep[CODE_W-1:0];
  assign bus.P = ep[CODE_W];
  assign bus.busy = busy;
  assign bus.done = done;
  assign bus.erros = erros;
  assign bus.count = cnt;
  assign bus.wr_ready = rdy;
endmodule
